mcp_sched: RTL and testbench

MCP_SCHED -- requirements
Module: mcp_sched

---
 rtl/mcp_sched_pkg.sv | 14 +
 rtl/mcp_sched_rr_arb2.sv | 18 +
 rtl/mcp_sched.sv | 95 +++++++++
 tb/tb_mcp_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_sched_pkg.sv
// Shared types and constants for the multicycle-path launch/capture scheduler.
package mcp_sched_pkg;

    localparam int CNT_W = 4;
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/mcp_sched_rr_arb2.sv
// Two-requester round-robin selector; purely combinational.
module rr_arb2
    import mcp_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            ptr,
    output logic            gnt_idx,
    output logic            gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[1];
        // Only a tie consults the pointer; a lone requester always wins.
        if (&req) gnt_idx = ptr;
    end

endmodule

// File: rtl/mcp_sched.sv
// Schedules one transaction at a time through a shared multicycle combinational path:
// launch register enable, MCP_CYCLES of settling, then capture register enable.
module mcp_sched
    import mcp_sched_pkg::*;
#(
    parameter int DW         = 4,
    parameter int MCP_CYCLES = 3
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   req_data0,
    input  logic [DW-1:0]   req_data1,
    output logic [NREQ-1:0] grant,
    output logic            launch_en,
    output logic [DW-1:0]   launch_data,
    output logic            capture_en,
    output logic            done,
    output logic            done_id,
    output logic            busy
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             winner;
    logic             ptr;
    logic             arb_idx;
    logic             arb_valid;
    logic             accept;

    rr_arb2 u_arb (
        .req       (req),
        .ptr       (ptr),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // CAPTURE may accept too, so a waiting requester launches with no idle bubble.
    assign accept = arb_valid && (state == IDLE || state == CAPTURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant      = '0;
        launch_en  = 1'b0;
        capture_en = 1'b0;
        done       = 1'b0;
        done_id    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                launch_en       = 1'b1;
                grant[winner]   = 1'b1;
                state_nxt       = (MCP_CYCLES == 1) ? CAPTURE : SETTLE;
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                capture_en = 1'b1;
                done       = 1'b1;
                done_id    = winner;
                state_nxt  = accept ? LAUNCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand and winner are frozen at acceptance and held until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= 1'b0;
            winner      <= 1'b0;
            launch_data <= '0;
            cnt         <= '0;
        end else begin
            if (accept) begin
                winner      <= arb_idx;
                ptr         <= ~arb_idx;
                launch_data <= arb_idx ? req_data1 : req_data0;
            end
            if (state == LAUNCH)      cnt <= CNT_W'(MCP_CYCLES - 1);
            else if (state == SETTLE) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mcp_sched.sv
// Scoreboard bench for mcp_sched: one instance at MCP_CYCLES=3, one at MCP_CYCLES=1.
module tb_mcp_sched;

    localparam int MCP_A = 3;
    localparam int MCP_B = 1;

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
        logic [3:0] ld;
        logic       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_a = 2'b00, req_b = 2'b00;
    logic [3:0] d0_a = 4'h0, d1_a = 4'h0, d0_b = 4'h0, d1_b = 4'h0;
    logic [1:0] grant_a, grant_b;
    logic       len_a, cen_a, done_a, did_a, busy_a;
    logic       len_b, cen_b, done_b, did_b, busy_b;
    logic [3:0] ld_a, ld_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int grants_a = 0, dones_a = 0, killed_a = 0;
    int grants_b = 0, dones_b = 0;

    exp_t lq[$];
    exp_t dq[$];

    mcp_sched #(.DW(4), .MCP_CYCLES(MCP_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data0(d0_a), .req_data1(d1_a),
        .grant(grant_a), .launch_en(len_a), .launch_data(ld_a), .capture_en(cen_a),
        .done(done_a), .done_id(did_a), .busy(busy_a)
    );

    mcp_sched #(.DW(4), .MCP_CYCLES(MCP_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data0(d0_b), .req_data1(d1_b),
        .grant(grant_b), .launch_en(len_b), .launch_data(ld_b), .capture_en(cen_b),
        .done(done_b), .done_id(did_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Invariants watched on every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((len_a && cen_a) || (len_b && cen_b)) begin
                errors++;
                $display("FAIL launch_capture_overlap cyc=%0d a=%b%b b=%b%b, need never both high", cyc, len_a, cen_a, len_b, cen_b);
            end
            checks++;
            if (!$onehot0(grant_a) || !$onehot0(grant_b)) begin
                errors++;
                $display("FAIL grant_onehot0 cyc=%0d grant_a=%b grant_b=%b", cyc, grant_a, grant_b);
            end
            checks++;
            if (cen_a !== done_a || cen_b !== done_b) begin
                errors++;
                $display("FAIL capture_done_pair cyc=%0d a=%b/%b b=%b/%b, need equal", cyc, cen_a, done_a, cen_b, done_b);
            end
            if (grant_a != 2'b00) grants_a++;
            if (grant_b != 2'b00) grants_b++;
            if (done_a) dones_a++;
            if (done_b) dones_b++;
        end
    end

    task automatic test_reset();
        rst = 1'b1; req_a = 2'b01; d0_a = 4'hA; req_b = 2'b10; d1_b = 4'h9;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant_a, len_a, cen_a, done_a, did_a, busy_a, ld_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs_a got %h, need 0", {grant_a, len_a, cen_a, done_a, did_a, busy_a, ld_a});
        end
        checks++;
        if ({grant_b, len_b, cen_b, done_b, did_b, busy_b, ld_b} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs_b got %h, need 0", {grant_b, len_b, cen_b, done_b, did_b, busy_b, ld_b});
        end
        req_a = 2'b00; req_b = 2'b00; d0_a = 4'h0; d1_b = 4'h0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy_a=%b busy_b=%b, need 0", busy_a, busy_b);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acc;
        int   ng = 0;
        @(negedge clk);
        req_a = 2'b11; d0_a = 4'h3; d1_a = 4'hC; acc = cyc;
        for (int k = 0; k < 3; k++) begin
            lq.push_back('{acc + 1 + (MCP_A + 1) * k, (k == 1) ? 2'b10 : 2'b01, (k == 1) ? 4'hC : 4'h3, 1'b0});
            dq.push_back('{acc + (MCP_A + 1) * (k + 1), 2'b00, 4'h0, (k == 1)});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (grant_a != 2'b00) begin
                ng++;
                if (ng == 3) req_a = 2'b00;
            end
            checks++;
            if (busy_a !== (cyc >= acc + 1 && cyc <= acc + 3 * (MCP_A + 1))) begin
                errors++;
                $display("FAIL b2b_busy cyc=%0d got %b", cyc, busy_a);
            end
            if (len_a) begin
                checks++;
                if (lq.size() > 0) e = lq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || grant_a !== e.gnt || ld_a !== e.ld) begin
                    errors++;
                    $display("FAIL b2b_launch got cyc=%0d grant=%b data=%h, need cyc=%0d grant=%b data=%h", cyc, grant_a, ld_a, e.cyc, e.gnt, e.ld);
                end
            end
            if (done_a) begin
                checks++;
                if (dq.size() > 0) e = dq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || cen_a !== 1'b1 || did_a !== e.id) begin
                    errors++;
                    $display("FAIL b2b_done got cyc=%0d cap=%b id=%b, need cyc=%0d cap=1 id=%b", cyc, cen_a, did_a, e.cyc, e.id);
                end
            end
        end
        checks++;
        if (lq.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending got %0d outstanding events, need 0", lq.size() + dq.size());
        end
        lq.delete(); dq.delete();
    endtask

    task automatic test_single();
        exp_t e;
        int   acc;
        @(negedge clk);
        req_a = 2'b01; d0_a = 4'hA; d1_a = 4'h0; acc = cyc;
        lq.push_back('{acc + 1, 2'b01, 4'hA, 1'b0});
        dq.push_back('{acc + MCP_A + 1, 2'b00, 4'h0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant_a != 2'b00) req_a = 2'b00;
            checks++;
            if (busy_a !== (cyc >= acc + 1 && cyc <= acc + MCP_A + 1)) begin
                errors++;
                $display("FAIL single_busy cyc=%0d got %b", cyc, busy_a);
            end
            if (len_a) begin
                checks++;
                if (lq.size() > 0) e = lq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || grant_a !== e.gnt || ld_a !== e.ld) begin
                    errors++;
                    $display("FAIL single_launch got cyc=%0d grant=%b data=%h, need cyc=%0d grant=%b data=%h", cyc, grant_a, ld_a, e.cyc, e.gnt, e.ld);
                end
            end
            if (done_a) begin
                checks++;
                if (dq.size() > 0) e = dq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || cen_a !== 1'b1 || did_a !== e.id) begin
                    errors++;
                    $display("FAIL single_done got cyc=%0d cap=%b id=%b, need cyc=%0d cap=1 id=%b", cyc, cen_a, did_a, e.cyc, e.id);
                end
            end
        end
        checks++;
        if (lq.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL single_pending got %0d outstanding events, need 0", lq.size() + dq.size());
        end
        lq.delete(); dq.delete();
    endtask

    task automatic test_operand_change();
        exp_t e;
        int   acc;
        @(negedge clk);
        req_a = 2'b01; d0_a = 4'h5; acc = cyc;
        lq.push_back('{acc + 1, 2'b01, 4'h5, 1'b0});
        dq.push_back('{acc + MCP_A + 1, 2'b00, 4'h0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant_a != 2'b00) req_a = 2'b00;
            if (cyc == acc + 2) d0_a = 4'hF;
            if (cyc >= acc + 1 && cyc <= acc + MCP_A + 1) begin
                checks++;
                if (ld_a !== 4'h5) begin
                    errors++;
                    $display("FAIL operand_hold cyc=%0d got %h, need 5", cyc, ld_a);
                end
            end
            if (len_a) begin
                checks++;
                if (lq.size() > 0) e = lq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || grant_a !== e.gnt || ld_a !== e.ld) begin
                    errors++;
                    $display("FAIL operand_launch got cyc=%0d grant=%b data=%h, need cyc=%0d grant=%b data=%h", cyc, grant_a, ld_a, e.cyc, e.gnt, e.ld);
                end
            end
            if (done_a) begin
                checks++;
                if (dq.size() > 0) e = dq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || did_a !== e.id) begin
                    errors++;
                    $display("FAIL operand_done got cyc=%0d id=%b, need cyc=%0d id=%b", cyc, did_a, e.cyc, e.id);
                end
            end
        end
        checks++;
        if (lq.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL operand_pending got %0d outstanding events, need 0", lq.size() + dq.size());
        end
        lq.delete(); dq.delete();
    endtask

    task automatic test_reset_mid_settle();
        exp_t e;
        int   acc;
        @(negedge clk);
        req_a = 2'b01; d0_a = 4'h7; acc = cyc;
        @(negedge clk);
        checks++;
        if (len_a !== 1'b1 || grant_a !== 2'b01) begin
            errors++;
            $display("FAIL kill_launch got len=%b grant=%b, need 1/01", len_a, grant_a);
        end
        req_a = 2'b00;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || len_a !== 1'b0 || cen_a !== 1'b0) begin
            errors++;
            $display("FAIL kill_settle got busy=%b len=%b cap=%b, need 1/0/0", busy_a, len_a, cen_a);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({grant_a, len_a, cen_a, done_a, did_a, busy_a, ld_a} !== 11'd0) begin
            errors++;
            $display("FAIL kill_async_clear got %h, need 0", {grant_a, len_a, cen_a, done_a, did_a, busy_a, ld_a});
        end
        killed_a++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || cen_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL kill_no_done cyc=%0d got done=%b cap=%b busy=%b, need 0", cyc, done_a, cen_a, busy_a);
            end
        end
        req_a = 2'b01; d0_a = 4'h6; acc = cyc;
        lq.push_back('{acc + 1, 2'b01, 4'h6, 1'b0});
        dq.push_back('{acc + MCP_A + 1, 2'b00, 4'h0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant_a != 2'b00) req_a = 2'b00;
            if (len_a) begin
                checks++;
                if (lq.size() > 0) e = lq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || grant_a !== e.gnt || ld_a !== e.ld) begin
                    errors++;
                    $display("FAIL rearm_launch got cyc=%0d grant=%b data=%h, need cyc=%0d grant=%b data=%h", cyc, grant_a, ld_a, e.cyc, e.gnt, e.ld);
                end
            end
            if (done_a) begin
                checks++;
                if (dq.size() > 0) e = dq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || did_a !== e.id) begin
                    errors++;
                    $display("FAIL rearm_done got cyc=%0d id=%b, need cyc=%0d id=%b", cyc, did_a, e.cyc, e.id);
                end
            end
        end
        checks++;
        if (lq.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL rearm_pending got %0d outstanding events, need 0", lq.size() + dq.size());
        end
        lq.delete(); dq.delete();
    endtask

    task automatic test_min_budget();
        exp_t e;
        int   acc;
        @(negedge clk);
        req_b = 2'b10; d0_b = 4'h2; d1_b = 4'h9; acc = cyc;
        lq.push_back('{acc + 1, 2'b10, 4'h9, 1'b0});
        dq.push_back('{acc + MCP_B + 1, 2'b00, 4'h0, 1'b1});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (grant_b != 2'b00) req_b = 2'b00;
            checks++;
            if (busy_b !== (cyc >= acc + 1 && cyc <= acc + MCP_B + 1)) begin
                errors++;
                $display("FAIL minbud_busy cyc=%0d got %b", cyc, busy_b);
            end
            if (len_b) begin
                checks++;
                if (lq.size() > 0) e = lq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || grant_b !== e.gnt || ld_b !== e.ld) begin
                    errors++;
                    $display("FAIL minbud_launch got cyc=%0d grant=%b data=%h, need cyc=%0d grant=%b data=%h", cyc, grant_b, ld_b, e.cyc, e.gnt, e.ld);
                end
            end
            if (done_b) begin
                checks++;
                if (dq.size() > 0) e = dq.pop_front(); else e = '{-1, 2'b00, 4'h0, 1'b0};
                if (cyc !== e.cyc || cen_b !== 1'b1 || did_b !== e.id) begin
                    errors++;
                    $display("FAIL minbud_done got cyc=%0d cap=%b id=%b, need cyc=%0d cap=1 id=%b", cyc, cen_b, did_b, e.cyc, e.id);
                end
            end
        end
        checks++;
        if (lq.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL minbud_pending got %0d outstanding events, need 0", lq.size() + dq.size());
        end
        lq.delete(); dq.delete();
    endtask

    task automatic test_counts();
        @(negedge clk);
        checks++;
        if (grants_a !== dones_a + killed_a || grants_a !== 7) begin
            errors++;
            $display("FAIL count_a got grants=%0d dones=%0d killed=%0d, need grants=7 and grants=dones+killed", grants_a, dones_a, killed_a);
        end
        checks++;
        if (grants_b !== dones_b || grants_b !== 1) begin
            errors++;
            $display("FAIL count_b got grants=%0d dones=%0d, need 1 and 1", grants_b, dones_b);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_operand_change();
        test_reset_mid_settle();
        test_min_budget();
        test_counts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
